// File: rtl/alarma_sirena_pkg.sv
// alarma_sirena_pkg
// Shared definitions for the car-alarm siren stage: FSM state codes,
// timer and event-counter widths, and a helper that turns a cycle count
// into the terminal-count value the timer compares against.
package alarma_sirena_pkg;

    localparam int TIMER_W  = 8;
    localparam int EVENTS_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_SOUND = 2'd2,
        S_COOL  = 2'd3
    } state_t;

    // A phase lasting n cycles ends when the timer reads n-1.
    function automatic logic [TIMER_W-1:0] tc_of(input int unsigned n);
        return TIMER_W'(n - 1);
    endfunction

endpackage

// File: rtl/alarma_sirena_temporizador.sv
// alarma_temporizador
// 8-bit up counter used as the single phase timer of alarma_sirena.
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   clear     in   synchronous clear (wins over enable)
//   enable    in   synchronous count enable
//   tc_value  in   terminal-count compare value
//   count     out  current timer value
//   tc        out  high when count equals tc_value
module alarma_temporizador
    import alarma_sirena_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [TIMER_W-1:0] tc_value,
    output logic [TIMER_W-1:0] count,
    output logic               tc
);

    localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

    // The all-ones guard keeps the counter from wrapping even if a caller
    // forgets to clear it at terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + ONE;
        end
    end

    assign tc = (count == tc_value);

endmodule

// File: rtl/alarma_sirena.sv
// alarma_sirena
// Sequential response stage of the car alarm. Confirms that the alarm
// condition persists, sounds the siren for a bounded time, honours a driver
// acknowledge, then blocks re-triggering for a cool-down period.
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   a       in   alarm condition from alarma
//   ack     in   driver acknowledge/silence (level-sampled)
//   siren   out  siren drive
//   light   out  blinking hazard light
//   active  out  high while confirming or sounding
//   events  out  saturating count of siren activations
module alarma_sirena
    import alarma_sirena_pkg::*;
#(
    parameter int unsigned CONFIRM  = 4,
    parameter int unsigned ON_TIME  = 32,
    parameter int unsigned BLINK    = 4,
    parameter int unsigned COOLDOWN = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                a,
    input  logic                ack,
    output logic                siren,
    output logic                light,
    output logic                active,
    output logic [EVENTS_W-1:0] events
);

    localparam logic [TIMER_W-1:0]  CONFIRM_TC = tc_of(CONFIRM);
    localparam logic [TIMER_W-1:0]  ON_TC      = tc_of(ON_TIME);
    localparam logic [TIMER_W-1:0]  COOL_TC    = tc_of(COOLDOWN);
    localparam logic [TIMER_W-1:0]  BLINK_DIV  = TIMER_W'(BLINK);
    localparam logic [TIMER_W-1:0]  T_ONE      = TIMER_W'(1);
    localparam logic [EVENTS_W-1:0] EV_ONE     = EVENTS_W'(1);

    state_t               state;
    state_t               next_state;
    logic [TIMER_W-1:0]   t;
    logic [TIMER_W-1:0]   tc_value;
    logic                 tc;
    logic                 t_clear;
    logic                 t_enable;
    logic                 enter_sound;

    alarma_temporizador u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (t_clear),
        .enable   (t_enable),
        .tc_value (tc_value),
        .count    (t),
        .tc       (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Every path into IDLE clears the timer, so IDLE always holds t=0 and
    // the IDLE->PEND step is a plain increment to 1: the IDLE sample of a
    // is the first of the CONFIRM confirmations.
    always_comb begin
        next_state  = state;
        t_clear     = 1'b0;
        t_enable    = 1'b0;
        tc_value    = '0;
        enter_sound = 1'b0;
        case (state)
            S_IDLE: begin
                if (a) begin
                    next_state = S_PEND;
                    t_enable   = 1'b1;
                end
            end
            S_PEND: begin
                tc_value = CONFIRM_TC;
                if (!a) begin
                    next_state = S_IDLE;
                    t_clear    = 1'b1;
                end else if (tc) begin
                    next_state  = S_SOUND;
                    t_clear     = 1'b1;
                    enter_sound = 1'b1;
                end else begin
                    t_enable = 1'b1;
                end
            end
            S_SOUND: begin
                tc_value = ON_TC;
                if (ack || tc) begin
                    next_state = S_COOL;
                    t_clear    = 1'b1;
                end else begin
                    t_enable = 1'b1;
                end
            end
            S_COOL: begin
                tc_value = COOL_TC;
                if (tc) begin
                    next_state = S_IDLE;
                    t_clear    = 1'b1;
                end else begin
                    t_enable = 1'b1;
                end
            end
            default: begin
                next_state = S_IDLE;
                t_clear    = 1'b1;
            end
        endcase
    end

    // Counts siren activations, sticking at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            events <= '0;
        end else if (enter_sound && (events != '1)) begin
            events <= events + EV_ONE;
        end
    end

    // Outputs decode only registered state and timer, so an asynchronous
    // reset clears them immediately. The light is on during the even
    // BLINK-long slices of the siren period, starting lit.
    assign siren  = (state == S_SOUND);
    assign light  = siren && (((t / BLINK_DIV) & T_ONE) == '0);
    assign active = (state == S_PEND) || (state == S_SOUND);

endmodule

// File: tb/tb_alarma_sirena.sv
// tb_alarma_sirena
// Self-checking bench for alarma_sirena with default parameters.
module tb_alarma_sirena;

    localparam int CONFIRM  = 4;
    localparam int ON_TIME  = 32;
    localparam int BLINK    = 4;
    localparam int COOLDOWN = 8;

    logic       clk;
    logic       rst_n;
    logic       a;
    logic       ack;
    logic       siren;
    logic       light;
    logic       active;
    logic [3:0] events;

    int checks = 0;
    int errors = 0;

    alarma_sirena #(
        .CONFIRM  (CONFIRM),
        .ON_TIME  (ON_TIME),
        .BLINK    (BLINK),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (a),
        .ack    (ack),
        .siren  (siren),
        .light  (light),
        .active (active),
        .events (events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: remaining cycles of siren, remaining cycles of
    // cool-down, and the current run of consecutive high samples of a.
    int m_streak     = 0;
    int m_sound_left = 0;
    int m_cool_left  = 0;
    int m_events     = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_streak     <= 0;
            m_sound_left <= 0;
            m_cool_left  <= 0;
            m_events     <= 0;
        end else if (m_cool_left > 0) begin
            m_cool_left <= m_cool_left - 1;
        end else if (m_sound_left > 0) begin
            if (ack || m_sound_left == 1) begin
                m_sound_left <= 0;
                m_cool_left  <= COOLDOWN;
            end else begin
                m_sound_left <= m_sound_left - 1;
            end
        end else if (a) begin
            if (m_streak + 1 == CONFIRM) begin
                m_streak     <= 0;
                m_sound_left <= ON_TIME;
                if (m_events < 15) m_events <= m_events + 1;
            end else begin
                m_streak <= m_streak + 1;
            end
        end else begin
            m_streak <= 0;
        end
    end

    function automatic int expSiren();
        return (m_sound_left > 0) ? 1 : 0;
    endfunction

    function automatic int expLight();
        if (m_sound_left == 0) return 0;
        return (((ON_TIME - m_sound_left) / BLINK) % 2 == 0) ? 1 : 0;
    endfunction

    function automatic int expActive();
        return (m_sound_left > 0 || m_streak > 0) ? 1 : 0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("model siren", int'(siren), expSiren());
            checkOutput("model light", int'(light), expLight());
            checkOutput("model active", int'(active), expActive());
            checkOutput("model events", int'(events), m_events);
        end
    end

    // Drives a/ack for n rising edges; starts and ends just after a falling edge.
    task automatic applyStimulus(input logic a_v, input logic ack_v, input int n);
        for (int i = 0; i < n; i++) begin
            a   = a_v;
            ack = ack_v;
            @(negedge clk);
        end
    endtask

    // Asserts reset between edges and checks outputs clear before any edge.
    task automatic pulseReset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        checkOutput({tag, " rst siren"}, int'(siren), 0);
        checkOutput({tag, " rst light"}, int'(light), 0);
        checkOutput({tag, " rst active"}, int'(active), 0);
        checkOutput({tag, " rst events"}, int'(events), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [31:0] pattern;
    int          siren_cycles;

    initial begin
        rst_n = 1'b0;
        a     = 1'b1;
        ack   = 1'b0;

        // Reset with a high: everything stays clear.
        #3;
        checkOutput("reset siren", int'(siren), 0);
        checkOutput("reset light", int'(light), 0);
        checkOutput("reset active", int'(active), 0);
        checkOutput("reset events", int'(events), 0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("trigger edge3 siren", int'(siren), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("trigger edge4 siren", int'(siren), 1);
        checkOutput("trigger events", int'(events), 1);
        applyStimulus(1'b0, 1'b0, 40);
        checkOutput("drain active", int'(active), 0);

        // Glitch: three highs then one low aborts confirmation.
        pulseReset("glitch");
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("glitch pend active", int'(active), 1);
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("glitch low active", int'(active), 0);
        checkOutput("glitch siren", int'(siren), 0);
        checkOutput("glitch events", int'(events), 0);

        // Full cycle with a held high.
        applyStimulus(1'b1, 1'b0, 4);
        pattern      = '0;
        siren_cycles = 0;
        for (int i = 0; i < ON_TIME + 4; i++) begin
            if (siren) siren_cycles++;
            if (i < 32) pattern = {pattern[30:0], light};
            applyStimulus(1'b1, 1'b0, 1);
        end
        checkOutput("full siren length", siren_cycles, 32);
        checkOutput("full light pattern", int'(pattern), int'(32'hF0F0F0F0));
        checkOutput("full events", int'(events), 1);
        // 4 cool cycles already passed in the loop above; 4 more end COOL.
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("cool end siren", int'(siren), 0);
        checkOutput("cool end active", int'(active), 0);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("retrigger edge3", int'(siren), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("retrigger edge4", int'(siren), 1);
        checkOutput("retrigger events", int'(events), 2);

        // Acknowledge on the 10th sound cycle.
        applyStimulus(1'b1, 1'b0, 9);
        checkOutput("ack pre siren", int'(siren), 1);
        applyStimulus(1'b1, 1'b1, 1);
        checkOutput("ack siren", int'(siren), 0);
        checkOutput("ack light", int'(light), 0);
        applyStimulus(1'b1, 1'b0, 8);
        checkOutput("ack cool done active", int'(active), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("ack new pend", int'(active), 1);
        applyStimulus(1'b0, 1'b0, 1);
        applyStimulus(1'b0, 1'b1, 3);
        checkOutput("idle ack active", int'(active), 0);
        checkOutput("idle ack siren", int'(siren), 0);
        checkOutput("idle ack events", int'(events), 2);

        // Saturation over 17 acknowledged alarm cycles.
        pulseReset("sat");
        for (int k = 0; k < 17; k++) begin
            applyStimulus(1'b1, 1'b0, 4);
            applyStimulus(1'b0, 1'b1, 1);
            applyStimulus(1'b0, 1'b0, 8);
        end
        checkOutput("sat events", int'(events), 15);
        applyStimulus(1'b1, 1'b0, 4);
        checkOutput("sat hold events", int'(events), 15);
        checkOutput("sat hold siren", int'(siren), 1);

        // Asynchronous reset in the middle of the siren period.
        applyStimulus(1'b1, 1'b0, 2);
        checkOutput("mid sound light", int'(light), 1);
        pulseReset("midsound");
        applyStimulus(1'b0, 1'b0, 1);
        checkOutput("post reset active", int'(active), 0);
        applyStimulus(1'b1, 1'b0, 3);
        checkOutput("post reset edge3", int'(siren), 0);
        applyStimulus(1'b1, 1'b0, 1);
        checkOutput("post reset edge4", int'(siren), 1);
        checkOutput("post reset events", int'(events), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
